ad9518_cfg_sched: RTL and testbench



---
 rtl/ad9518_cfg_pkg.sv | 20 ++
 rtl/ad9518_cfg_fifo.sv | 42 ++++
 rtl/ad9518_cfg_sched.sv | 113 +++++++++++
 tb/tb_ad9518_cfg_sched.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ad9518_cfg_pkg.sv
// ad9518_cfg_pkg: shared types, widths and the optional boot ROM for the AD9518 config scheduler.
// The ROM exists only when AD9518_BOOT_SEQ_EN is defined.
package ad9518_cfg_pkg;
  localparam int CMD_W = 24;
  localparam int BOOT_LEN = 55;
  localparam int TIMEOUT_DEF = 4096;
  typedef enum logic [1:0] {IDLE, BOOT_WAIT, ARM_WAIT, GAP} state_t;
`ifdef AD9518_BOOT_SEQ_EN
  // {addr[15:0], data[7:0]}, sent in index order; the last write is the IO update
  localparam logic [CMD_W-1:0] BOOT_ROM [BOOT_LEN] = '{
    24'h000018, 24'h000400, 24'h00107C, 24'h001101, 24'h001200, 24'h001303, 24'h001400, 24'h001504,
    24'h001606, 24'h001700, 24'h001800, 24'h001900, 24'h001A00, 24'h001B00, 24'h001C02, 24'h001D00,
    24'h001E00, 24'h001F0E, 24'h00A000, 24'h00A100, 24'h00A200, 24'h00A300, 24'h00A400, 24'h00A500,
    24'h00A600, 24'h00A700, 24'h00A800, 24'h00A900, 24'h00AA00, 24'h00AB00, 24'h00F008, 24'h00F108,
    24'h00F208, 24'h00F308, 24'h00F408, 24'h00F508, 24'h014042, 24'h014142, 24'h014242, 24'h014342,
    24'h019000, 24'h019100, 24'h019200, 24'h019300, 24'h019400, 24'h019500, 24'h019600, 24'h019700,
    24'h019800, 24'h019900, 24'h01E000, 24'h01E102, 24'h023000, 24'h023100, 24'h023201
  };
`endif
endpackage

// File: rtl/ad9518_cfg_fifo.sv
// ad9518_cfg_fifo: ARM command queue with a fall-through head.
// An entry written into an empty queue becomes visible at the head one cycle later.
module ad9518_cfg_fifo import ad9518_cfg_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [CMD_W-1:0] din,
  output logic [CMD_W-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             head_valid
);
  localparam int AW = $clog2(DEPTH);
  logic [CMD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic fresh, do_push, do_pop;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign head_valid = ~empty & ~fresh;
  assign head = mem[rptr];
  // a full queue refuses the push even when a pop frees a slot in the same cycle
  assign do_push = push & ~full;
  assign do_pop = pop & head_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      fresh <= 1'b0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
      fresh <= do_push & empty;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
endmodule

// File: rtl/ad9518_cfg_sched.sv
// ad9518_cfg_sched: shares the AD9518 SPI config engine between the boot ROM and queued ARM writes.
// Define AD9518_BOOT_SEQ_EN to compile in the boot sequence; otherwise only ARM commands are served.
module ad9518_cfg_sched import ad9518_cfg_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm_cfg_en,
  input  logic [CMD_W-1:0] arm_cfg_data,
  output logic             arm_cfg_full,
  input  logic             cfg_end,
  output logic             cfg_en,
  output logic [CMD_W-1:0] cfg_data,
  output logic             boot_done,
  output logic             busy,
  output logic             drop_err,
  output logic             timeout_err
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic en_n, terr_n, pop, fifo_empty, head_valid;
  logic [CMD_W-1:0] data_n, head;
  logic [TW-1:0] tcnt, tcnt_n;
`ifdef AD9518_BOOT_SEQ_EN
  localparam int IW = $clog2(BOOT_LEN + 1);
  logic [IW-1:0] idx, idx_n;
  logic done_n;
`else
  assign boot_done = 1'b1;
`endif
  ad9518_cfg_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(arm_cfg_en), .pop(pop), .din(arm_cfg_data),
    .head(head), .full(arm_cfg_full), .empty(fifo_empty), .head_valid(head_valid)
  );
  assign busy = (state != IDLE) | ~fifo_empty;
  always_comb begin
    state_n = state;
    en_n = cfg_en;
    data_n = cfg_data;
    tcnt_n = tcnt;
    terr_n = timeout_err;
    pop = 1'b0;
`ifdef AD9518_BOOT_SEQ_EN
    idx_n = idx;
    done_n = boot_done;
`endif
    case (state)
      IDLE: begin
`ifdef AD9518_BOOT_SEQ_EN
        if (!boot_done) begin
          data_n = BOOT_ROM[idx];
          en_n = 1'b1;
          tcnt_n = '0;
          state_n = BOOT_WAIT;
        end else
`endif
        if (head_valid) begin
          pop = 1'b1;
          data_n = head;
          en_n = 1'b1;
          tcnt_n = '0;
          state_n = ARM_WAIT;
        end
      end
      BOOT_WAIT, ARM_WAIT: begin
        // an abandoned command is not retried; the boot index advances either way
        if (cfg_end || tcnt == T_LAST) begin
          en_n = 1'b0;
          state_n = GAP;
          terr_n = timeout_err | ~cfg_end;
`ifdef AD9518_BOOT_SEQ_EN
          idx_n = idx + IW'(state == BOOT_WAIT);
`endif
        end else tcnt_n = tcnt + 1'b1;
      end
      GAP: begin
        state_n = IDLE;
`ifdef AD9518_BOOT_SEQ_EN
        done_n = boot_done | (idx == IW'(BOOT_LEN));
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cfg_en <= 1'b0;
      cfg_data <= '0;
      tcnt <= '0;
      timeout_err <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      state <= state_n;
      cfg_en <= en_n;
      cfg_data <= data_n;
      tcnt <= tcnt_n;
      timeout_err <= terr_n;
      drop_err <= drop_err | (arm_cfg_en & arm_cfg_full);
    end
`ifdef AD9518_BOOT_SEQ_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      boot_done <= 1'b0;
    end else begin
      idx <= idx_n;
      boot_done <= done_n;
    end
`endif
endmodule

// File: tb/tb_ad9518_cfg_sched.sv
// tb_ad9518_cfg_sched: directed checks of scheduling, latency, FIFO overflow, timeout and reset.
// Exercises the boot path as well when AD9518_BOOT_SEQ_EN is defined.
module tb_ad9518_cfg_sched;
  logic clk = 1'b0, rst_n = 1'b1, arm_cfg_en = 1'b0, cfg_end = 1'b0;
  logic [23:0] arm_cfg_data = '0;
  logic arm_cfg_full, cfg_en, boot_done, busy, drop_err, timeout_err;
  logic [23:0] cfg_data;
  int n_chk = 0, n_fail = 0;
  ad9518_cfg_sched dut (
    .clk(clk), .rst_n(rst_n), .arm_cfg_en(arm_cfg_en), .arm_cfg_data(arm_cfg_data),
    .arm_cfg_full(arm_cfg_full), .cfg_end(cfg_end), .cfg_en(cfg_en), .cfg_data(cfg_data),
    .boot_done(boot_done), .busy(busy), .drop_err(drop_err), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(input logic [23:0] d);
    arm_cfg_data = d;
    arm_cfg_en = 1'b1;
    @(negedge clk);
    arm_cfg_en = 1'b0;
  endtask
  task automatic end_pulse;
    cfg_end = 1'b1;
    @(negedge clk);
    cfg_end = 1'b0;
  endtask
  task automatic wait_en(input string tag);
    int i = 0;
    while (!cfg_en && i < 200) begin
      @(negedge clk);
      i++;
    end
    chk(tag, cfg_en, 1);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    step(2);
    chk("rst_en", cfg_en, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", arm_cfg_full, 0);
    chk("rst_drop", drop_err, 0);
    chk("rst_terr", timeout_err, 0);
    rst_n = 1'b1;
`ifdef AD9518_BOOT_SEQ_EN
    chk("rst_boot_done", boot_done, 0);
    for (int i = 0; i < 55; i++) begin
      wait_en("boot_en");
      if (i == 0) chk("boot_first", cfg_data, 24'h000018);
      if (i == 54) chk("boot_last", cfg_data, 24'h023201);
      if (i == 10) push(24'h00A001);
      else step(1);
      step(3);
      end_pulse;
    end
    chk("boot_end_en", cfg_en, 0);
    chk("boot_done_early", boot_done, 0);
    step(1);
    chk("boot_done", boot_done, 1);
    step(1);
    chk("held_en", cfg_en, 1);
    chk("held_data", cfg_data, 24'h00A001);
    chk("held_drop", drop_err, 0);
    end_pulse;
`else
    chk("rst_boot_done", boot_done, 1);
    push(24'h00A001);
    chk("lat_k0", cfg_en, 0);
    step(1);
    chk("lat_k1", cfg_en, 0);
    chk("lat_k1_data", cfg_data, 0);
    step(1);
    chk("lat_k2", cfg_en, 1);
    chk("lat_k2_data", cfg_data, 24'h00A001);
    end_pulse;
    chk("lat_end", cfg_en, 0);
`endif
    // stall the engine on one command, then overfill the queue behind it
    push(24'h00B001);
    wait_en("stall_en");
    chk("stall_data", cfg_data, 24'h00B001);
    for (int i = 0; i < 5; i++) begin
      arm_cfg_data = 24'h00C000 + 24'(i);
      arm_cfg_en = 1'b1;
      @(negedge clk);
      if (i == 3) begin
        chk("fill_full", arm_cfg_full, 1);
        chk("fill_drop", drop_err, 0);
      end
    end
    arm_cfg_en = 1'b0;
    chk("ovf_drop", drop_err, 1);
    chk("ovf_full", arm_cfg_full, 1);
    for (int i = 0; i < 4; i++) begin
      end_pulse;
      chk("b2b_low0", cfg_en, 0);
      step(1);
      chk("b2b_low1", cfg_en, 0);
      step(1);
      chk("b2b_high", cfg_en, 1);
      chk("b2b_data", cfg_data, 24'h00C000 + 24'(i));
    end
    end_pulse;
    step(3);
    chk("drain_en", cfg_en, 0);
    chk("drain_full", arm_cfg_full, 0);
    chk("drain_busy", busy, 0);
    // engine never answers the first command
    push(24'h001807);
    push(24'h002233);
    wait_en("to_en");
    chk("to_data", cfg_data, 24'h001807);
    step(4095);
    chk("to_pre_en", cfg_en, 1);
    chk("to_pre_err", timeout_err, 0);
    step(1);
    chk("to_en_drop", cfg_en, 0);
    chk("to_err", timeout_err, 1);
    step(1);
    chk("to_gap", cfg_en, 0);
    step(1);
    chk("to_next_en", cfg_en, 1);
    chk("to_next_data", cfg_data, 24'h002233);
    end_pulse;
    // reset while a command is in flight with two entries behind it
    push(24'h00E001);
    push(24'h00E002);
    push(24'h00E003);
    wait_en("rr_en");
    chk("rr_data", cfg_data, 24'h00E001);
    chk("rr_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_en_low", cfg_en, 0);
    chk("rr_data_clr", cfg_data, 0);
    chk("rr_busy_clr", busy, 0);
    chk("rr_terr_clr", timeout_err, 0);
    chk("rr_drop_clr", drop_err, 0);
    chk("rr_full_clr", arm_cfg_full, 0);
`ifdef AD9518_BOOT_SEQ_EN
    chk("rr_boot_done", boot_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_en("rr_boot_en");
    chk("rr_boot_idx0", cfg_data, 24'h000018);
`else
    chk("rr_boot_done", boot_done, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    chk("rr_no_issue", cfg_en, 0);
    chk("rr_empty", busy, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
